controlador_configuracion: RTL and testbench
============================================

Name: controlador_configuracion

Overview:
Sequences the RTC display's configuration mode. Takes five debounced push-button levels and produces the config_mode, cursor_location and parpadeo controls that the text generator uses to highlight the field being edited. Also produces one-cycle increment, decrement and commit strobes that go to the RTC register/write path. Sits between the button debouncers and both the character generator and the RTC interface controller.

Parameters:
BLINK_CYCLES, 25000000, parpadeo half-period in clk cycles (>=2).
TIMEOUT_CYCLES, 1000000000, idle cycles in a config mode before automatic exit (>=2, fits 32 bits).

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
btn_config  in  1  debounced, synchronized level; cycles the mode
btn_up  in  1  debounced level; increment the selected field
btn_down  in  1  debounced level; decrement the selected field
btn_left  in  1  debounced level; move cursor left
btn_right  in  1  debounced level; move cursor right
config_mode  out  2  0 normal, 1 hora, 2 fecha, 3 timer
cursor_location  out  2  0 rightmost pair, 1 middle, 2 leftmost, 3 AM/PM (hora) or dia_semana (fecha)
parpadeo  out  1  cursor blink phase
inc_pulse  out  1  one-cycle increment strobe
dec_pulse  out  1  one-cycle decrement strobe
commit  out  1  one-cycle strobe on leaving a config mode
commit_mode  out  2  mode being exited; valid while commit=1, held otherwise

Behaviour:
- Reset values: all outputs 0; blink counter and idle counter 0; button history registers 1, so a button held through reset release produces no press.
- Press detection: press_x = btn_x & ~btn_x_q, where btn_x_q is the previous sample. All outputs are registered. A press updates the outputs at the same rising edge where it is first seen.
- Single action per cycle, priority: config > up > down > left > right. Lower-priority presses in the same cycle are discarded, not queued.
- Mode FSM:
  - Transitions: MODE0 -> MODE1 -> MODE2 -> MODE3 -> MODE0 on press_config.
  - Entering any nonzero mode: cursor_location=0, blink counter=0, parpadeo=1, idle counter=0.
  - Entering MODE0 (by button or timeout): cursor_location=0, parpadeo=0, commit=1 for one cycle, commit_mode = exited mode, registered at the same edge.
- Cursor max: MODE1=3, MODE2=3, MODE3=2.
  - press_left: location+1, wrapping from max to 0.
  - press_right: location-1, wrapping from 0 to max.
- Up/down: in a nonzero mode, inc_pulse or dec_pulse = 1 for exactly one cycle. A held button produces one pulse only. Consumers decode the field from config_mode and cursor_location, which are stable during the pulse.
- MODE0: up, down, left and right are ignored (no pulses, no state change). parpadeo=0. Both counters are held at 0.
- Blink: in a nonzero mode the counter runs 0..BLINK_CYCLES-1; at terminal count it wraps to 0 and parpadeo toggles. Any accepted press in a nonzero mode clears the counter and sets parpadeo=1.
- Timeout:
  - In a nonzero mode the idle counter increments every cycle and is cleared by any accepted press.
  - At count TIMEOUT_CYCLES-1 the block goes to MODE0 with a commit, exactly as for a button exit.
  - A press in the same cycle as terminal count wins: the press is executed, the counter clears, and there is no timeout.
- Strobes: inc_pulse, dec_pulse and commit are mutually exclusive and never asserted for two consecutive cycles from a single press.
- Asynchronous reset mid-operation: immediate return to reset values. No commit is issued.

Test Plan:
- Reset, then a press of btn_config held 5 cycles -> config_mode=1, cursor=0, parpadeo=1, commit=0. Mode stays 1 while the button is held and until it is released and pressed again.
- MODE3: btn_left x3 -> cursor 1,2,0. btn_right at 0 -> cursor 2. Separately in MODE1: btn_left x4 from 0 -> 1,2,3,0.
- MODE2, cursor=3, btn_up held 10 cycles -> inc_pulse high exactly 1 cycle, config_mode=2 and cursor=3 during the pulse. Same in MODE0 -> no pulse.
- BLINK_CYCLES=4, MODE1, idle -> parpadeo toggles every 4 cycles. btn_right mid-period -> parpadeo=1 and the counter restarts.
- TIMEOUT_CYCLES=20, MODE2 idle -> config_mode=0 at the 20th cycle with commit=1 and commit_mode=2 for one cycle. A repeat with btn_down pressed at the terminal cycle -> dec_pulse, stays in MODE2, and the counter restarts.
- btn_config and btn_up pressed in the same cycle in MODE3 -> config_mode=0, commit=1 with commit_mode=3, inc_pulse=0. Reset asserted mid-MODE1 -> all outputs 0, no commit.

Source files
------------

// File: rtl/controlador_configuracion.sv
// Configuration-mode sequencer for the RTC display: turns debounced button levels into
// mode/cursor/blink controls for the text generator and one-cycle edit strobes for the RTC.
module controlador_configuracion #(
    parameter int unsigned BLINK_CYCLES   = 32'd25000000,
    parameter int unsigned TIMEOUT_CYCLES = 32'd1000000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_config,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [1:0] config_mode,
    output logic [1:0] cursor_location,
    output logic       parpadeo,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       commit,
    output logic [1:0] commit_mode
);

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_CONFIG = 3'd1,
        ACT_UP     = 3'd2,
        ACT_DOWN   = 3'd3,
        ACT_LEFT   = 3'd4,
        ACT_RIGHT  = 3'd5
    } action_t;

    localparam logic [31:0] BLINK_LAST   = 32'(BLINK_CYCLES - 32'd1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 32'd1);

    // Button order in the vectors below: {config, up, down, left, right}
    logic [4:0]  btn_s;
    logic [4:0]  press_s;
    logic [4:0]  btn_q_r;
    action_t     action_s;
    mode_t       mode_next_s;
    logic [1:0]  cursor_max_s;
    logic [1:0]  cursor_left_s;
    logic [1:0]  cursor_right_s;

    mode_t       mode_r;
    logic [1:0]  cursor_r;
    logic        parpadeo_r;
    logic        inc_r;
    logic        dec_r;
    logic        commit_r;
    logic [1:0]  commit_mode_r;
    logic [31:0] blink_cnt_r;
    logic [31:0] idle_cnt_r;

    assign btn_s   = {btn_config, btn_up, btn_down, btn_left, btn_right};
    assign press_s = btn_s & ~btn_q_r;

    // Pick the single highest-priority new press; the rest are dropped this cycle
    always_comb begin
        action_s = ACT_NONE;
        if (press_s[4]) begin
            action_s = ACT_CONFIG;
        end else if (press_s[3]) begin
            action_s = ACT_UP;
        end else if (press_s[2]) begin
            action_s = ACT_DOWN;
        end else if (press_s[1]) begin
            action_s = ACT_LEFT;
        end else if (press_s[0]) begin
            action_s = ACT_RIGHT;
        end else begin
            action_s = ACT_NONE;
        end
    end

    // Next mode in the config cycle and cursor wrap limits for the current mode
    always_comb begin
        mode_next_s  = MODE0;
        cursor_max_s = 2'd3;
        case (mode_r)
            MODE0:   mode_next_s = MODE1;
            MODE1:   mode_next_s = MODE2;
            MODE2:   mode_next_s = MODE3;
            MODE3:   mode_next_s = MODE0;
            default: mode_next_s = MODE0;
        endcase
        if (mode_r == MODE3) begin
            cursor_max_s = 2'd2;
        end else begin
            cursor_max_s = 2'd3;
        end
        if (cursor_r == cursor_max_s) begin
            cursor_left_s = 2'd0;
        end else begin
            cursor_left_s = cursor_r + 2'd1;
        end
        if (cursor_r == 2'd0) begin
            cursor_right_s = cursor_max_s;
        end else begin
            cursor_right_s = cursor_r - 2'd1;
        end
    end

    // Mode FSM with cursor, blink, idle-timeout and strobe registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q_r       <= 5'b11111;
            mode_r        <= MODE0;
            cursor_r      <= 2'd0;
            parpadeo_r    <= 1'b0;
            inc_r         <= 1'b0;
            dec_r         <= 1'b0;
            commit_r      <= 1'b0;
            commit_mode_r <= 2'd0;
            blink_cnt_r   <= 32'd0;
            idle_cnt_r    <= 32'd0;
        end else begin
            btn_q_r  <= btn_s;
            inc_r    <= 1'b0;
            dec_r    <= 1'b0;
            commit_r <= 1'b0;
            if (mode_r == MODE0) begin
                blink_cnt_r <= 32'd0;
                idle_cnt_r  <= 32'd0;
                parpadeo_r  <= 1'b0;
                if (action_s == ACT_CONFIG) begin
                    mode_r     <= MODE1;
                    cursor_r   <= 2'd0;
                    parpadeo_r <= 1'b1;
                end
            end else if (action_s != ACT_NONE) begin
                blink_cnt_r <= 32'd0;
                idle_cnt_r  <= 32'd0;
                parpadeo_r  <= 1'b1;
                case (action_s)
                    ACT_CONFIG: begin
                        mode_r   <= mode_next_s;
                        cursor_r <= 2'd0;
                        if (mode_next_s == MODE0) begin
                            parpadeo_r    <= 1'b0;
                            commit_r      <= 1'b1;
                            commit_mode_r <= mode_r;
                        end
                    end
                    ACT_UP:    inc_r    <= 1'b1;
                    ACT_DOWN:  dec_r    <= 1'b1;
                    ACT_LEFT:  cursor_r <= cursor_left_s;
                    ACT_RIGHT: cursor_r <= cursor_right_s;
                    default: begin
                    end
                endcase
            end else if (idle_cnt_r == TIMEOUT_LAST) begin
                // Idle exit behaves exactly like a config-button exit
                mode_r        <= MODE0;
                cursor_r      <= 2'd0;
                parpadeo_r    <= 1'b0;
                commit_r      <= 1'b1;
                commit_mode_r <= mode_r;
                blink_cnt_r   <= 32'd0;
                idle_cnt_r    <= 32'd0;
            end else begin
                idle_cnt_r <= idle_cnt_r + 32'd1;
                if (blink_cnt_r == BLINK_LAST) begin
                    blink_cnt_r <= 32'd0;
                    parpadeo_r  <= ~parpadeo_r;
                end else begin
                    blink_cnt_r <= blink_cnt_r + 32'd1;
                end
            end
        end
    end

    assign config_mode     = mode_r;
    assign cursor_location = cursor_r;
    assign parpadeo        = parpadeo_r;
    assign inc_pulse       = inc_r;
    assign dec_pulse       = dec_r;
    assign commit          = commit_r;
    assign commit_mode     = commit_mode_r;

endmodule

// File: tb/tb_controlador_configuracion.sv
// Directed bench for controlador_configuracion with short blink (4) and timeout (20) periods.
module tb_controlador_configuracion;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_config = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic [1:0] config_mode;
    logic [1:0] cursor_location;
    logic       parpadeo;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       commit;
    logic [1:0] commit_mode;

    int n_cmp  = 0;
    int n_fail = 0;

    controlador_configuracion #(.BLINK_CYCLES(32'd4), .TIMEOUT_CYCLES(32'd20)) dut (
        .clk(clk), .reset(reset), .btn_config(btn_config), .btn_up(btn_up),
        .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .config_mode(config_mode), .cursor_location(cursor_location), .parpadeo(parpadeo),
        .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .commit(commit), .commit_mode(commit_mode)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tap_config();
        btn_config = 1'b1; step();
        btn_config = 1'b0; step();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        step();
        n_cmp++; if (config_mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode got %0d want 0", config_mode); end
        n_cmp++; if (cursor_location !== 2'd0) begin n_fail++; $display("FAIL reset_cursor got %0d want 0", cursor_location); end
        n_cmp++; if (parpadeo !== 1'b0) begin n_fail++; $display("FAIL reset_parpadeo got %b want 0", parpadeo); end
        n_cmp++; if ({inc_pulse, dec_pulse, commit} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes got %b want 000", {inc_pulse, dec_pulse, commit}); end
        n_cmp++; if (commit_mode !== 2'd0) begin n_fail++; $display("FAIL reset_commit_mode got %0d want 0", commit_mode); end
        btn_config = 1'b0;
        step();
    endtask

    task automatic test_config_hold();
        btn_config = 1'b1; step();
        n_cmp++; if (config_mode !== 2'd1) begin n_fail++; $display("FAIL enter_mode got %0d want 1", config_mode); end
        n_cmp++; if (cursor_location !== 2'd0) begin n_fail++; $display("FAIL enter_cursor got %0d want 0", cursor_location); end
        n_cmp++; if (parpadeo !== 1'b1) begin n_fail++; $display("FAIL enter_parpadeo got %b want 1", parpadeo); end
        n_cmp++; if (commit !== 1'b0) begin n_fail++; $display("FAIL enter_commit got %b want 0", commit); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (config_mode !== 2'd1) begin n_fail++; $display("FAIL hold_mode got %0d want 1", config_mode); end
        end
        btn_config = 1'b0; step();
        n_cmp++; if (config_mode !== 2'd1) begin n_fail++; $display("FAIL release_mode got %0d want 1", config_mode); end
    endtask

    task automatic test_cursor();
        for (int i = 1; i <= 4; i++) begin
            btn_left = 1'b1; step();
            n_cmp++; if (cursor_location !== 2'(i % 4)) begin n_fail++; $display("FAIL m1_left got %0d want %0d", cursor_location, i % 4); end
            btn_left = 1'b0; step();
        end
        tap_config();
        tap_config();
        n_cmp++; if (config_mode !== 2'd3) begin n_fail++; $display("FAIL to_m3 got %0d want 3", config_mode); end
        for (int i = 1; i <= 3; i++) begin
            btn_left = 1'b1; step();
            n_cmp++; if (cursor_location !== 2'(i % 3)) begin n_fail++; $display("FAIL m3_left got %0d want %0d", cursor_location, i % 3); end
            btn_left = 1'b0; step();
        end
        btn_right = 1'b1; step();
        n_cmp++; if (cursor_location !== 2'd2) begin n_fail++; $display("FAIL m3_right_wrap got %0d want 2", cursor_location); end
        btn_right = 1'b0; step();
        btn_config = 1'b1; step();
        n_cmp++; if (config_mode !== 2'd0) begin n_fail++; $display("FAIL m3_exit_mode got %0d want 0", config_mode); end
        n_cmp++; if (commit !== 1'b1 || commit_mode !== 2'd3) begin n_fail++; $display("FAIL m3_exit_commit got %b/%0d want 1/3", commit, commit_mode); end
        n_cmp++; if (cursor_location !== 2'd0 || parpadeo !== 1'b0) begin n_fail++; $display("FAIL m3_exit_cur_blink got %0d/%b want 0/0", cursor_location, parpadeo); end
        btn_config = 1'b0; step();
        n_cmp++; if (commit !== 1'b0) begin n_fail++; $display("FAIL commit_one_cycle got %b want 0", commit); end
    endtask

    task automatic test_up_down();
        int n_inc;
        tap_config();
        tap_config();
        for (int i = 0; i < 3; i++) begin
            btn_left = 1'b1; step(); btn_left = 1'b0; step();
        end
        n_cmp++; if (config_mode !== 2'd2 || cursor_location !== 2'd3) begin n_fail++; $display("FAIL m2_setup got %0d/%0d want 2/3", config_mode, cursor_location); end
        btn_up = 1'b1; step();
        n_cmp++; if (inc_pulse !== 1'b1 || dec_pulse !== 1'b0) begin n_fail++; $display("FAIL up_pulse got inc %b dec %b want 1 0", inc_pulse, dec_pulse); end
        n_cmp++; if (config_mode !== 2'd2 || cursor_location !== 2'd3) begin n_fail++; $display("FAIL up_field got %0d/%0d want 2/3", config_mode, cursor_location); end
        n_inc = 0;
        repeat (9) begin step(); n_inc += int'(inc_pulse); end
        btn_up = 1'b0; step(); n_inc += int'(inc_pulse);
        n_cmp++; if (n_inc !== 0) begin n_fail++; $display("FAIL up_held_extra got %0d want 0", n_inc); end
        tap_config();
        tap_config();
        n_cmp++; if (config_mode !== 2'd0) begin n_fail++; $display("FAIL back_m0 got %0d want 0", config_mode); end
        btn_up = 1'b1; btn_left = 1'b1;
        n_inc = 0;
        repeat (10) begin step(); n_inc += int'(inc_pulse); end
        n_cmp++; if (n_inc !== 0) begin n_fail++; $display("FAIL m0_up_pulses got %0d want 0", n_inc); end
        n_cmp++; if (cursor_location !== 2'd0 || config_mode !== 2'd0) begin n_fail++; $display("FAIL m0_ignore got %0d/%0d want 0/0", cursor_location, config_mode); end
        btn_up = 1'b0; btn_left = 1'b0; step();
    endtask

    task automatic test_blink();
        btn_config = 1'b1; step();
        n_cmp++; if (config_mode !== 2'd1 || parpadeo !== 1'b1) begin n_fail++; $display("FAIL blink_enter got %0d/%b want 1/1", config_mode, parpadeo); end
        btn_config = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step();
            n_cmp++; if (parpadeo !== (((k / 4) % 2) == 0)) begin n_fail++; $display("FAIL blink_k%0d got %b want %b", k, parpadeo, ((k / 4) % 2) == 0); end
        end
        btn_right = 1'b1; step();
        n_cmp++; if (parpadeo !== 1'b1 || cursor_location !== 2'd3) begin n_fail++; $display("FAIL blink_right got %b/%0d want 1/3", parpadeo, cursor_location); end
        btn_right = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_cmp++; if (parpadeo !== (k < 4)) begin n_fail++; $display("FAIL blink_restart_k%0d got %b want %b", k, parpadeo, k < 4); end
        end
    endtask

    task automatic test_timeout();
        btn_config = 1'b1; step();
        btn_config = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            step();
            if (k < 20) begin
                n_cmp++; if (config_mode !== 2'd2 || commit !== 1'b0) begin n_fail++; $display("FAIL to_wait_k%0d got %0d/%b want 2/0", k, config_mode, commit); end
            end else if (k == 20) begin
                n_cmp++; if (config_mode !== 2'd0 || commit !== 1'b1 || commit_mode !== 2'd2) begin n_fail++; $display("FAIL to_exit got %0d/%b/%0d want 0/1/2", config_mode, commit, commit_mode); end
            end else begin
                n_cmp++; if (commit !== 1'b0 || commit_mode !== 2'd2) begin n_fail++; $display("FAIL to_after got %b/%0d want 0/2", commit, commit_mode); end
            end
        end
        tap_config();
        btn_config = 1'b1; step();
        btn_config = 1'b0;
        repeat (19) step();
        btn_down = 1'b1; step();
        n_cmp++; if (dec_pulse !== 1'b1 || config_mode !== 2'd2 || commit !== 1'b0) begin n_fail++; $display("FAIL to_press_wins got %b/%0d/%b want 1/2/0", dec_pulse, config_mode, commit); end
        btn_down = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 19) begin
                n_cmp++; if (config_mode !== 2'd2) begin n_fail++; $display("FAIL to_restart_hold got %0d want 2", config_mode); end
            end else if (k == 20) begin
                n_cmp++; if (config_mode !== 2'd0 || commit !== 1'b1) begin n_fail++; $display("FAIL to_restart_exit got %0d/%b want 0/1", config_mode, commit); end
            end
        end
    endtask

    task automatic test_same_cycle();
        tap_config(); tap_config(); tap_config();
        n_cmp++; if (config_mode !== 2'd3) begin n_fail++; $display("FAIL sc_setup got %0d want 3", config_mode); end
        btn_config = 1'b1; btn_up = 1'b1; step();
        n_cmp++; if (config_mode !== 2'd0 || commit !== 1'b1 || commit_mode !== 2'd3) begin n_fail++; $display("FAIL sc_exit got %0d/%b/%0d want 0/1/3", config_mode, commit, commit_mode); end
        n_cmp++; if (inc_pulse !== 1'b0) begin n_fail++; $display("FAIL sc_no_inc got %b want 0", inc_pulse); end
        btn_config = 1'b0; btn_up = 1'b0; step();
    endtask

    task automatic test_reset_mid();
        tap_config();
        step();
        n_cmp++; if (config_mode !== 2'd1) begin n_fail++; $display("FAIL rm_setup got %0d want 1", config_mode); end
        reset = 1'b1;
        #1;
        n_cmp++; if ({config_mode, cursor_location, parpadeo, inc_pulse, dec_pulse, commit, commit_mode} !== 10'd0) begin n_fail++; $display("FAIL rm_async got %b want 0", {config_mode, cursor_location, parpadeo, inc_pulse, dec_pulse, commit, commit_mode}); end
        step();
        n_cmp++; if (commit !== 1'b0 || config_mode !== 2'd0) begin n_fail++; $display("FAIL rm_held got %b/%0d want 0/0", commit, config_mode); end
        reset = 1'b0;
        step();
        n_cmp++; if (commit !== 1'b0 || config_mode !== 2'd0) begin n_fail++; $display("FAIL rm_release got %b/%0d want 0/0", commit, config_mode); end
    endtask

    initial begin
        test_reset();
        test_config_hold();
        test_cursor();
        test_up_down();
        test_blink();
        test_timeout();
        test_same_cycle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
